id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 55 +++++
 rtl/id_stage_regfile.sv | 56 +++++
 rtl/id_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: instruction field encodings,
// ALU operation encoding and the ID/EX pipeline record.
package id_stage_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
  } idex_t;

  function automatic logic [XLEN-1:0] sign_extend16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports with writeback bypass,
// one synchronous write port; register 0 is hardwired to zero.
module regfile
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_addr != '0)) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // A same-cycle writeback wins over the stored value so decode sees it.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (wb_we && (wb_addr == rs_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (wb_we && (wb_addr == rt_addr)) begin
      rt_data = wb_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, decoder, load-use hazard
// detection, register file and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [XLEN-1:0]   if_instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs_data,
  output logic [XLEN-1:0]   ex_rt_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic [2:0]        ex_alu_op
);

  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  idex_t           idex_q, idex_d;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs, rt, rd;
  ctrl_t             dec_ctrl;
  logic              dec_known;
  logic              uses_rt;
  logic [XLEN-1:0]   rf_rs_data, rf_rt_data;

  assign opcode = ifid_instr_q[31:26];
  assign rs     = ifid_instr_q[25:21];
  assign rt     = ifid_instr_q[20:16];
  assign rd     = ifid_instr_q[15:11];
  assign funct  = ifid_instr_q[5:0];

  regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rf_rs_data),
    .rt_data (rf_rt_data),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // Anything not recognised here (including the all-zero word) decodes to a NOP.
  always_comb begin
    dec_ctrl  = '0;
    dec_known = 1'b0;
    uses_rt   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        case (funct)
          FN_ADD: begin dec_known = 1'b1; dec_ctrl.alu_op = ALU_ADD; end
          FN_SUB: begin dec_known = 1'b1; dec_ctrl.alu_op = ALU_SUB; end
          FN_AND: begin dec_known = 1'b1; dec_ctrl.alu_op = ALU_AND; end
          FN_OR:  begin dec_known = 1'b1; dec_ctrl.alu_op = ALU_OR;  end
          FN_SLT: begin dec_known = 1'b1; dec_ctrl.alu_op = ALU_SLT; end
          default: dec_known = 1'b0;
        endcase
        dec_ctrl.reg_write = dec_known;
        dec_ctrl.reg_dst   = dec_known;
      end
      OP_ADDI: begin
        dec_known          = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
      end
      OP_LW: begin
        dec_known          = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
      end
      OP_SW: begin
        dec_known          = 1'b1;
        uses_rt            = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        dec_known       = 1'b1;
        uses_rt         = 1'b1;
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
      end
      default: dec_known = 1'b0;
    endcase
  end

  // Load-use hazard: the load in EX produces a register this word still needs.
  always_comb begin
    stall = ifid_valid_q && idex_q.ctrl.mem_read && (idex_q.rt != '0) &&
            ((idex_q.rt == rs) || (uses_rt && (idex_q.rt == rt)));
  end

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
    end else if (!stall) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = if_pc;
      ifid_instr_d = if_instr;
    end
  end

  // Flush, stall and NOP all leave an all-zero bubble in ID/EX.
  always_comb begin
    idex_d = '0;
    if (!flush && !stall && ifid_valid_q && dec_known) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = ifid_pc_q;
      idex_d.rs_data = rf_rs_data;
      idex_d.rt_data = rf_rt_data;
      idex_d.imm     = sign_extend16(ifid_instr_q[15:0]);
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.rd      = rd;
      idex_d.ctrl    = dec_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      idex_q       <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      idex_q       <= idex_d;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_rs_data   = idex_q.rs_data;
  assign ex_rt_data   = idex_q.rt_data;
  assign ex_imm       = idex_q.imm;
  assign ex_rs        = idex_q.rs;
  assign ex_rt        = idex_q.rt;
  assign ex_rd        = idex_q.rd;
  assign ex_reg_write = idex_q.ctrl.reg_write;
  assign ex_mem_read  = idex_q.ctrl.mem_read;
  assign ex_mem_write = idex_q.ctrl.mem_write;
  assign ex_alu_src   = idex_q.ctrl.alu_src;
  assign ex_reg_dst   = idex_q.ctrl.reg_dst;
  assign ex_branch    = idex_q.ctrl.branch;
  assign ex_alu_op    = idex_q.ctrl.alu_op;

endmodule
